// File: rtl/div_gen.sv
// ============================================================================
// div_gen - sequential integer divider, one quotient bit per clock.
//
// Computes quotient and remainder of WIDTH-bit operands with runtime-selectable
// signed / unsigned mode. Division by zero and signed overflow behave as in
// the RISC-V M extension: both are defined results, not errors.
//
// Parameters:
//   WIDTH      operand / result width (4..64), default 32
//   SIGNED_EN  0 removes the signed datapath; is_signed is then ignored
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   init       start request, sampled only while idle
//   is_signed  1 = two's-complement operands, sampled with init
//   op_A       dividend, sampled with init
//   op_B       divisor, sampled with init
//   busy       high from the accepting edge until done
//   done       one-cycle pulse when quotient/remainder are valid
//   quotient   registered quotient
//   remainder  registered remainder
//   div_zero   last operation had a zero divisor
//
// Latency: done rises WIDTH+2 edges after the edge that accepts init,
// independent of operand values. A new init is accepted in the done cycle.
// ============================================================================
module div_gen #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             init,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_A,
    input  logic [WIDTH-1:0] op_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;       // dividend as presented
    logic [WIDTH-1:0] b_reg;       // divisor as presented
    logic             sgn_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] mag_b_reg;   // |B|
    logic [WIDTH-1:0] q_reg;       // starts as |A|, shifts out into R
    logic [WIDTH:0]   r_reg;       // partial remainder
    logic [CW-1:0]    count_reg;

    // ------------------------------------------------------------------------
    // Operand magnitudes. Without signed support the magnitudes are the raw
    // operands and no negation hardware is built.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             sgn_in;

    generate
        if (SIGNED_EN != 0) begin : g_signed
            assign sgn_in = is_signed;
            always_comb begin
                abs_a = a_reg;
                abs_b = b_reg;
                if (sgn_reg && a_reg[WIDTH-1]) begin
                    abs_a = ~a_reg + 1'b1;
                end
                if (sgn_reg && b_reg[WIDTH-1]) begin
                    abs_b = ~b_reg + 1'b1;
                end
            end
        end else begin : g_unsigned
            assign sgn_in = 1'b0;
            assign abs_a  = a_reg;
            assign abs_b  = b_reg;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shift + trial subtract, one bit per cycle. The shifted remainder is kept
    // one bit wider than R so the borrow out of the subtraction lands in a bit
    // of its own and serves as the "negative result" flag.
    // ------------------------------------------------------------------------
    logic [WIDTH+1:0] r_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    assign r_shift  = {r_reg, q_reg[WIDTH-1]};
    assign trial    = r_shift - {2'b00, mag_b_reg};
    assign trial_ok = ~trial[WIDTH+1];

    // ------------------------------------------------------------------------
    // Final sign correction. Negating the low WIDTH bits of R equals
    // negating R and truncating, since R < |B| fits in WIDTH bits.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             b_zero;

    assign q_fix  = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
    assign r_fix  = neg_r_reg ? (~r_reg[WIDTH-1:0] + 1'b1) : r_reg[WIDTH-1:0];
    assign b_zero = (b_reg == '0);

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            mag_b_reg <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            count_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (init) begin
                        a_reg     <= op_A;
                        b_reg     <= op_B;
                        sgn_reg   <= sgn_in;
                        busy      <= 1'b1;
                        state_reg <= S_PREP;
                    end
                end

                S_PREP: begin
                    q_reg     <= abs_a;
                    mag_b_reg <= abs_b;
                    neg_q_reg <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_r_reg <= sgn_reg & a_reg[WIDTH-1];
                    r_reg     <= '0;
                    count_reg <= COUNT_INIT;
                    state_reg <= S_ITER;
                end

                S_ITER: begin
                    if (trial_ok) begin
                        r_reg <= trial[WIDTH:0];
                    end else begin
                        r_reg <= r_shift[WIDTH:0];
                    end
                    q_reg     <= {q_reg[WIDTH-2:0], trial_ok};
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == COUNT_LAST) begin
                        state_reg <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (b_zero) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        div_zero  <= 1'b0;
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_gen.sv
// ============================================================================
// tb_div_gen - directed self-checking bench for div_gen.
//
// Two instances share clock and reset: a 32-bit signed-capable divider and an
// 8-bit unsigned-only one. Each transaction prints one line; expected values
// are hand-computed constants.
// ============================================================================
module tb_div_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;

    logic        init;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    logic        init8;
    logic        is_signed8;
    logic [7:0]  op_a8;
    logic [7:0]  op_b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  quotient8;
    logic [7:0]  remainder8;
    logic        div_zero8;

    int n_checks = 0;
    int n_fail   = 0;

    div_gen #(.WIDTH(32), .SIGNED_EN(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .init      (init),
        .is_signed (is_signed),
        .op_A      (op_a),
        .op_B      (op_b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    div_gen #(.WIDTH(8), .SIGNED_EN(0)) dut8 (
        .clk       (clk),
        .resetn    (resetn),
        .init      (init8),
        .is_signed (is_signed8),
        .op_A      (op_a8),
        .op_B      (op_b8),
        .busy      (busy8),
        .done      (done8),
        .quotient  (quotient8),
        .remainder (remainder8),
        .div_zero  (div_zero8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One 32-bit transaction. If poke > 0, a second init (50/5) is pulsed
    // that many cycles after the accepting edge and must be ignored.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int poke);
        int   edges;
        logic busy_ok;
        @(negedge clk);
        op_a = a; op_b = b; is_signed = s; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; is_signed = ~s;
        check({tag, " busy_after_init"}, 64'(busy), 64'd1);
        edges   = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            init = 1'b0;
            if (done) begin
                edges = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (n == poke) begin
                init = 1'b1; op_a = 32'd50; op_b = 32'd5; is_signed = 1'b0;
            end
        end
        check({tag, " latency"}, 64'(edges), 64'd34);
        check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_drop"}, 64'(busy), 64'd0);
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        $display("[%0t] %s: %h / %h signed=%0d -> q=%h r=%h dz=%0d edges=%0d",
                 $time, tag, a, b, s, quotient, remainder, div_zero, edges);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] eq, input logic [7:0] er,
                        input logic edz);
        int edges;
        @(negedge clk);
        op_a8 = a; op_b8 = b; is_signed8 = s; init8 = 1'b1;
        @(posedge clk); #1;
        init8 = 1'b0; op_a8 = 8'h55; op_b8 = 8'h00;
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                edges = n;
                break;
            end
        end
        check({tag, " latency"}, 64'(edges), 64'd10);
        check({tag, " quotient"}, 64'(quotient8), 64'(eq));
        check({tag, " remainder"}, 64'(remainder8), 64'(er));
        check({tag, " div_zero"}, 64'(div_zero8), 64'(edz));
        $display("[%0t] %s: %h / %h signed=%0d -> q=%h r=%h dz=%0d edges=%0d",
                 $time, tag, a, b, s, quotient8, remainder8, div_zero8, edges);
    endtask

    initial begin
        logic seen_done;
        resetn = 1'b1;
        init = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        init8 = 1'b0; is_signed8 = 1'b0; op_a8 = '0; op_b8 = '0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run32("udiv 100/7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 0);
        run32("sdiv -7/2",      32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
        run32("sdiv 7/-2",      32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 0);
        run32("sdiv -7/-2",     32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0, 0);
        run32("sdiv 5/0",       32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 0);
        run32("udiv 5/0",       32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 0);
        run32("sdiv -8/0",      32'hFFFF_FFF8,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1, 0);
        run32("udiv 9/3",       32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 0);
        run32("sdiv overflow",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 0);
        run32("udiv minneg",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 0);
        run32("udiv max/1",     32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 0);
        run32("init ignored",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 5);

        // Reset in the middle of ITER: outputs clear at once, no done follows.
        @(negedge clk);
        op_a = 32'd1000; op_b = 32'd3; is_signed = 1'b0; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset quotient", 64'(quotient), 64'd0);
        check("midreset remainder", 64'(remainder), 64'd0);
        check("midreset div_zero", 64'(div_zero), 64'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("midreset no_done", 64'(seen_done), 64'd0);
        $display("[%0t] midreset: outputs cleared, no done after abort", $time);

        run32("after reset 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 0);

        run8("w8 nosigned F9/02", 8'hF9, 8'h02, 1'b1, 8'h7C, 8'h01, 1'b0);
        run8("w8 div0",           8'h2A, 8'h00, 1'b1, 8'hFF, 8'h2A, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_gen.md
# div_gen

Parametrised sequential integer divider, the successor to the fixed 16-bit restoring divider used as the femtoriscv coprocessor. It computes quotient and remainder of `WIDTH`-bit operands, one bit per clock, with runtime-selectable signed or unsigned mode. Its semantics match the RISC-V M extension: division by zero and signed overflow are defined cases, not errors. It sits behind the core's memory-mapped peripheral bus and is controlled with an `init`/`busy`/`done` handshake.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4..64.
- `SIGNED_EN`, default 1: when 0, signed hardware is removed and `is_signed` is ignored, so all operations are unsigned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `init`  in  1  start request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands; sampled with `init`.
- `op_A`  in  WIDTH  dividend; sampled with `init`.
- `op_B`  in  WIDTH  divisor; sampled with `init`.
- `busy`  out  1  high from the edge after `init` is accepted until `done` is asserted.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_zero`  out  1  set when the last operation had `op_B == 0`.

## Operation
- Reset (`resetn` low, at any time including mid-operation): state goes to IDLE; `busy`, `done`, `div_zero`, `quotient` and `remainder` go to 0; any operation in flight is discarded.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- **IDLE:** `done` is 0. If `init` is 1, latch `op_A`, `op_B` and `sgn = is_signed & SIGNED_EN`, set `busy` to 1, then go to PREP.
- **PREP:**
  - Store the magnitudes `|A|` and `|B|` as WIDTH-bit unsigned values. Take the absolute value only when `sgn` is 1 and the operand's MSB is 1.
  - Record `neg_q = sgn & (A[MSB] ^ B[MSB])` and `neg_r = sgn & A[MSB]`.
  - Clear the partial remainder `R` (WIDTH+1 bits). Set `count = WIDTH`. Go to ITER.
- **ITER**, one cycle per bit:
  - `{R, Q} <= {R, Q} << 1`.
  - Trial subtract: `R_shifted − |B|`. If the result is non-negative, take it as the new `R` and set `Q[0] = 1`; otherwise keep `R_shifted` and set `Q[0] = 0`.
  - Decrement `count`. When `count` reaches 0 after the update, go to FIX.
  - Shift and subtract happen in the same cycle.
- **FIX:**
  - If the latched divisor is 0: `quotient = all ones`, `remainder = latched op_A` (unmodified), `div_zero = 1`.
  - Otherwise: `quotient = neg_q ? −Q : Q` and `remainder = neg_r ? −R : R`, both truncated to WIDTH; `div_zero = 0`.
  - Set `done = 1` and `busy = 0`, then go to IDLE.
- **Signed overflow** (most-negative / −1): the result falls out naturally as `quotient = most-negative`, `remainder = 0`. No special logic is required beyond the WIDTH truncation.
- `init` while `busy` is 1 is ignored. It is not queued.
- Inputs may change freely after the accepting edge.
- `quotient`, `remainder` and `div_zero` hold their values until the next FIX or reset.

## Timing
- Edge 0 samples `init = 1` in IDLE. `busy` is high after edge 0.
- Edge 1: PREP. Edges 2 .. WIDTH+1: ITER. Edge WIDTH+2: FIX.
- `done` is high for exactly one cycle, after edge WIDTH+2 (34 edges for WIDTH=32). `busy` falls on the same edge.
- Latency is constant and independent of operand values, sign mode and division by zero.
- A new `init` can be accepted on edge WIDTH+3, which is the cycle in which `done` is high. Back-to-back throughput is therefore one result every WIDTH+3 cycles.
- There is no combinational path from any input to any output.

## Test plan
- **Unsigned:** WIDTH=32, `is_signed=0`, 100 / 7 -> `quotient=14`, `remainder=2`, `div_zero=0`. `done` pulses one cycle, exactly 34 edges after the `init` edge; `busy` is high throughout.
- **Signed:** −7 / 2 -> `quotient=0xFFFFFFFD` (−3), `remainder=0xFFFFFFFF` (−1). Also 7 / −2 -> `quotient=0xFFFFFFFD`, `remainder=1`.
- **Divide by zero:** 5 / 0, signed and unsigned -> `quotient=0xFFFFFFFF`, `remainder=5`, `div_zero=1`. A following 9 / 3 clears `div_zero` and gives `quotient=3`, `remainder=0`.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF with `is_signed=1` -> `quotient=0x80000000`, `remainder=0`. The same operands with `is_signed=0` -> `quotient=0`, `remainder=0x80000000`.
- **Handshake and reset:** pulse `init` again 5 cycles into an operation -> it is ignored and the first result is unaffected. Drop `resetn` at ITER cycle 10 -> all outputs become 0 immediately and no `done` appears. A subsequent `init` completes normally.
- **SIGNED_EN=0, WIDTH=8:** `is_signed=1`, 0xF9 / 0x02 -> `quotient=0x7C`, `remainder=0x01`. `done` arrives 10 edges after `init`.
